multicycle_controller: RTL and testbench

//  Multi-cycle control FSM for the R/I/J CPU, the successor to the single-cycle decoder.

---
 rtl/multicycle_controller_pkg.sv | 73 +++++++
 rtl/multicycle_controller_if.sv | 40 ++++
 rtl/multicycle_controller_decode.sv | 88 ++++++++
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multi-cycle R/I/J control path.
// Contents: opcode/funct encodings, ALU_OP codes, mux select encodings,
// FSM state encoding and the instruction-class enum produced by the decoder.
package multicycle_controller_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (IR[5:0]); and/or/xor/nor share the 1001xx group
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_SLTU   = 6'b101011;
  localparam logic [5:0] F_SLLV   = 6'b000100;
  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [3:0] F_LOGIC_HI = 4'b1001;

  // ALU operation codes
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLLV = 3'b111;

  // PC mux
  localparam logic [1:0] PC_S_INC  = 2'b00;
  localparam logic [1:0] PC_S_RS   = 2'b01;
  localparam logic [1:0] PC_S_BR   = 2'b10;
  localparam logic [1:0] PC_S_JUMP = 2'b11;

  // Destination register mux
  localparam logic [1:0] WRS_RD = 2'b00;
  localparam logic [1:0] WRS_RT = 2'b01;
  localparam logic [1:0] WRS_RA = 2'b10;

  // Write-data mux
  localparam logic [1:0] WDS_ALU = 2'b00;
  localparam logic [1:0] WDS_MEM = 2'b01;
  localparam logic [1:0] WDS_PC4 = 2'b10;

  // FSM state encoding
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  typedef enum logic [3:0] {
    CLS_R,     // R-type ALU op
    CLS_RJR,   // jr
    CLS_IALU,  // immediate ALU op
    CLS_LW,
    CLS_SW,
    CLS_BR,    // beq / bne
    CLS_J,
    CLS_JAL,
    CLS_ILL    // unknown opcode / funct
  } instr_class_e;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle controller and its datapath/memory.
// master: the controller (drives control word, memory request).
// slave : datapath/memory side (drives IR fields, ZF, mem_ready).
// Signals: opcode, funct, ZF, mem_ready (datapath -> controller);
//          mem_req, MemWrite, IR_we, PC_we, PC_s, w_r_s, w_r_data_s, imm_s,
//          rt_imm_s, ALU_OP, WriteReg, instr_done, illegal, mem_err (controller -> datapath).
interface multicycle_controller_if #(
  parameter int ALU_OP_W = 3
);
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                ZF;
  logic                mem_ready;
  logic                mem_req;
  logic                MemWrite;
  logic                IR_we;
  logic                PC_we;
  logic [1:0]          PC_s;
  logic [1:0]          w_r_s;
  logic [1:0]          w_r_data_s;
  logic                imm_s;
  logic                rt_imm_s;
  logic [ALU_OP_W-1:0] ALU_OP;
  logic                WriteReg;
  logic                instr_done;
  logic                illegal;
  logic                mem_err;

  modport master (
    input  opcode, funct, ZF, mem_ready,
    output mem_req, MemWrite, IR_we, PC_we, PC_s, w_r_s, w_r_data_s,
           imm_s, rt_imm_s, ALU_OP, WriteReg, instr_done, illegal, mem_err
  );

  modport slave (
    output opcode, funct, ZF, mem_ready,
    input  mem_req, MemWrite, IR_we, PC_we, PC_s, w_r_s, w_r_data_s,
           imm_s, rt_imm_s, ALU_OP, WriteReg, instr_done, illegal, mem_err
  );
endinterface

// File: rtl/multicycle_controller_decode.sv
// Instruction decoder (ctrl_decode) for the multi-cycle controller. Purely combinational.
// Ports:
//   opcode, funct : IR fields
//   cls           : instruction class
//   alu_op        : 3-bit ALU operation for the EXEC/MEM phases
//   imm_s         : 1 = sign-extend immediate
// JAL_EN = 0 makes jal decode as illegal.
module multicycle_controller_decode
  import multicycle_controller_pkg::*;
#(
  parameter int JAL_EN = 1
) (
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e cls,
  output logic [2:0]   alu_op,
  output logic         imm_s
);

  always_comb begin
    cls    = CLS_ILL;
    alu_op = ALU_AND;
    imm_s  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == F_ADD) begin
          cls    = CLS_R;
          alu_op = ALU_ADD;
        end else if (funct == F_SUB) begin
          cls    = CLS_R;
          alu_op = ALU_SUB;
        end else if (funct[5:2] == F_LOGIC_HI) begin
          // and/or/xor/nor map straight onto ALU codes 000..011
          cls    = CLS_R;
          alu_op = {1'b0, funct[1:0]};
        end else if (funct == F_SLTU) begin
          cls    = CLS_R;
          alu_op = ALU_SLTU;
        end else if (funct == F_SLLV) begin
          cls    = CLS_R;
          alu_op = ALU_SLLV;
        end else if (funct == F_JR) begin
          cls    = CLS_RJR;
        end
      end
      OP_LW: begin
        cls    = CLS_LW;
        alu_op = ALU_ADD;
        imm_s  = 1'b1;
      end
      OP_SW: begin
        cls    = CLS_SW;
        alu_op = ALU_ADD;
        imm_s  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        cls    = CLS_BR;
        alu_op = ALU_SUB;
      end
      OP_J:   cls = CLS_J;
      OP_JAL: cls = (JAL_EN != 0) ? CLS_JAL : CLS_ILL;
      OP_ADDI: begin
        cls    = CLS_IALU;
        alu_op = ALU_ADD;
        imm_s  = 1'b1;
      end
      OP_ANDI: begin
        cls    = CLS_IALU;
        alu_op = ALU_AND;
      end
      OP_ORI: begin
        cls    = CLS_IALU;
        alu_op = ALU_OR;
      end
      OP_XORI: begin
        cls    = CLS_IALU;
        alu_op = ALU_XOR;
      end
      OP_SLTIU: begin
        cls    = CLS_IALU;
        alu_op = ALU_SLTU;
        imm_s  = 1'b1;
      end
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the R/I/J CPU.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, issues the control word
// per state and handshakes with a wait-state memory via mem_req/mem_ready.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset; forces every output to 0 while high
//   bus : controller side of multicycle_controller_if (IR fields, ZF, memory handshake,
//         control word, instr_done/illegal/mem_err status)
//
// state  | meaning
// FETCH  | read instruction; IR/PC load on mem_ready
// DECODE | jumps complete here, illegal instructions flagged
// EXEC   | ALU controls valid; branches and jr complete
// MEM    | lw/sw data access; sw completes on mem_ready
// WB     | register-file write
// ERR    | memory timeout; terminal until rst, only mem_err high
module multicycle_controller #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 0,
  parameter int JAL_EN      = 1
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);
  import multicycle_controller_pkg::*;

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  instr_class_e cls;
  logic [2:0]   dec_alu_op;
  logic         dec_imm_s;

  logic       mem_req_c, mem_write_c, ir_we_c, pc_we_c;
  logic [1:0] pc_s_c, w_r_s_c, w_r_data_s_c;
  logic       imm_s_c, rt_imm_s_c;
  logic [2:0] alu_op_c;
  logic       write_reg_c, instr_done_c, illegal_c;
  logic       waiting;

  multicycle_controller_decode #(.JAL_EN(JAL_EN)) u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls),
    .alu_op (dec_alu_op),
    .imm_s  (dec_imm_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    pc_s_c       = PC_S_INC;
    w_r_s_c      = WRS_RD;
    w_r_data_s_c = WDS_ALU;
    imm_s_c      = 1'b0;
    rt_imm_s_c   = 1'b0;
    alu_op_c     = ALU_AND;
    write_reg_c  = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    waiting      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = ST_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      ST_DECODE: begin
        case (cls)
          CLS_J: begin
            pc_we_c      = 1'b1;
            pc_s_c       = PC_S_JUMP;
            instr_done_c = 1'b1;
            state_d      = ST_FETCH;
          end
          CLS_JAL: begin
            pc_we_c      = 1'b1;
            pc_s_c       = PC_S_JUMP;
            write_reg_c  = 1'b1;
            w_r_s_c      = WRS_RA;
            w_r_data_s_c = WDS_PC4;
            instr_done_c = 1'b1;
            state_d      = ST_FETCH;
          end
          CLS_ILL: begin
            illegal_c    = 1'b1;
            instr_done_c = 1'b1;
            state_d      = ST_FETCH;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls)
          CLS_R: begin
            alu_op_c = dec_alu_op;
            state_d  = ST_WB;
          end
          CLS_IALU: begin
            alu_op_c   = dec_alu_op;
            imm_s_c    = dec_imm_s;
            rt_imm_s_c = 1'b1;
            state_d    = ST_WB;
          end
          CLS_LW, CLS_SW: begin
            alu_op_c   = dec_alu_op;
            imm_s_c    = dec_imm_s;
            rt_imm_s_c = 1'b1;
            state_d    = ST_MEM;
          end
          CLS_BR: begin
            // beq takes on ZF, bne (opcode[0] = 1) on !ZF
            alu_op_c     = dec_alu_op;
            pc_s_c       = PC_S_BR;
            pc_we_c      = bus.ZF ^ bus.opcode[0];
            instr_done_c = 1'b1;
            state_d      = ST_FETCH;
          end
          CLS_RJR: begin
            pc_we_c      = 1'b1;
            pc_s_c       = PC_S_RS;
            instr_done_c = 1'b1;
            state_d      = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        // address controls held so the ALU keeps presenting the effective address
        mem_req_c   = 1'b1;
        mem_write_c = (cls == CLS_SW);
        alu_op_c    = dec_alu_op;
        imm_s_c     = dec_imm_s;
        rt_imm_s_c  = 1'b1;
        if (bus.mem_ready) begin
          if (cls == CLS_SW) begin
            instr_done_c = 1'b1;
            state_d      = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      ST_WB: begin
        write_reg_c  = 1'b1;
        instr_done_c = 1'b1;
        w_r_s_c      = (cls == CLS_R) ? WRS_RD : WRS_RT;
        w_r_data_s_c = (cls == CLS_LW) ? WDS_MEM : WDS_ALU;
        state_d      = ST_FETCH;
      end
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_FETCH;
    endcase

    if (waiting && (MEM_TIMEOUT > 0)) begin
      if (int'(cnt_q) + 1 >= MEM_TIMEOUT) state_d = ST_ERR;
      else                                cnt_d   = cnt_q + 1'b1;
    end
    // every state change starts a fresh wait count
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset gates the control word directly so an in-flight access is dropped at once.
  assign bus.mem_req    = mem_req_c & ~rst;
  assign bus.MemWrite   = mem_write_c & ~rst;
  assign bus.IR_we      = ir_we_c & ~rst;
  assign bus.PC_we      = pc_we_c & ~rst;
  assign bus.PC_s       = rst ? 2'b00 : pc_s_c;
  assign bus.w_r_s      = rst ? 2'b00 : w_r_s_c;
  assign bus.w_r_data_s = rst ? 2'b00 : w_r_data_s_c;
  assign bus.imm_s      = imm_s_c & ~rst;
  assign bus.rt_imm_s   = rt_imm_s_c & ~rst;
  assign bus.ALU_OP     = rst ? '0 : ALU_OP_W'(alu_op_c);
  assign bus.WriteReg   = write_reg_c & ~rst;
  assign bus.instr_done = instr_done_c & ~rst;
  assign bus.illegal    = illegal_c & ~rst;
  assign bus.mem_err    = (state_q == ST_ERR) & ~rst;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_s;
    logic [1:0] w_r_s;
    logic [1:0] w_r_data_s;
    logic       imm_s;
    logic       rt_imm_s;
    logic [2:0] alu_op;
    logic       write_reg;
    logic       instr_done;
    logic       illegal;
    logic       mem_err;
  } cw_t;

  typedef struct {
    cw_t   cw;
    string tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode_t = '0;
  logic [5:0] funct_t = '0;
  logic       zf_t = 1'b0;
  logic       rdy_t = 1'b0;
  logic       idle_rdy = 1'b0;
  bit         chk2 = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  multicycle_controller_if #(.ALU_OP_W(3)) bus1 ();
  multicycle_controller_if #(.ALU_OP_W(3)) bus2 ();

  assign bus1.opcode = opcode_t;
  assign bus1.funct = funct_t;
  assign bus1.ZF = zf_t;
  assign bus1.mem_ready = rdy_t;
  assign bus2.opcode = opcode_t;
  assign bus2.funct = funct_t;
  assign bus2.ZF = zf_t;
  assign bus2.mem_ready = rdy_t;

  multicycle_controller #(.ALU_OP_W(3), .MEM_TIMEOUT(4), .JAL_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  multicycle_controller #(.ALU_OP_W(3), .MEM_TIMEOUT(0), .JAL_EN(0)) dut_nojal (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  cw_t ob1, ob2;
  assign ob1 = {bus1.mem_req, bus1.MemWrite, bus1.IR_we, bus1.PC_we, bus1.PC_s, bus1.w_r_s,
                bus1.w_r_data_s, bus1.imm_s, bus1.rt_imm_s, bus1.ALU_OP, bus1.WriteReg,
                bus1.instr_done, bus1.illegal, bus1.mem_err};
  assign ob2 = {bus2.mem_req, bus2.MemWrite, bus2.IR_we, bus2.PC_we, bus2.PC_s, bus2.w_r_s,
                bus2.w_r_data_s, bus2.imm_s, bus2.rt_imm_s, bus2.ALU_OP, bus2.WriteReg,
                bus2.instr_done, bus2.illegal, bus2.mem_err};

  // Field order in the printed words:
  // req wr irwe pcwe pcs wrs wds imm rtimm alu wreg done ill err
  task automatic chk(input string name, input cw_t got, input cw_t exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b required %b", name, $time, got, exp);
    end
  endtask

  // Monitor: pops one expected control word per cycle and compares mid-cycle.
  exp_t m1, m2;
  always @(negedge clk) begin
    if (q1.size() > 0) begin
      m1 = q1.pop_front();
      chk({"dut.", m1.tag}, ob1, m1.cw);
    end
    if (q2.size() > 0) begin
      m2 = q2.pop_front();
      chk({"dut_nojal.", m2.tag}, ob2, m2.cw);
    end
  end

  task automatic cyc(input logic r, input logic z, input cw_t e, input string tag);
    rdy_t = r;
    zf_t = z;
    q1.push_back('{cw: e, tag: tag});
    if (chk2) q2.push_back('{cw: e, tag: tag});
    @(posedge clk);
    #1;
  endtask

  task automatic cycd(input cw_t e1, input cw_t e2, input string tag);
    rdy_t = idle_rdy;
    zf_t = 1'b0;
    q1.push_back('{cw: e1, tag: tag});
    q2.push_back('{cw: e2, tag: tag});
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    opcode_t = op;
    funct_t = fn;
  endtask

  task automatic fetch(input int waits);
    cw_t e = '0;
    e.mem_req = 1'b1;
    repeat (waits) cyc(1'b0, 1'b0, e, "fetch_wait");
    e.ir_we = 1'b1;
    e.pc_we = 1'b1;
    e.pc_s = 2'b00;
    cyc(1'b1, 1'b0, e, "fetch");
  endtask

  task automatic decode_go();
    cyc(idle_rdy, 1'b0, '0, "decode");
  endtask

  task automatic r_alu(input logic [5:0] fn, input logic [2:0] alu);
    cw_t e = '0;
    set_ir(6'b000000, fn);
    fetch(0);
    decode_go();
    e.alu_op = alu;
    cyc(idle_rdy, 1'b0, e, "exec_r");
    e = '0;
    e.write_reg = 1'b1;
    e.instr_done = 1'b1;
    cyc(idle_rdy, 1'b0, e, "wb_r");
  endtask

  task automatic i_alu(input logic [5:0] op, input logic [2:0] alu, input logic imm);
    cw_t e = '0;
    set_ir(op, 6'b010101);
    fetch(0);
    decode_go();
    e.alu_op = alu;
    e.imm_s = imm;
    e.rt_imm_s = 1'b1;
    cyc(idle_rdy, 1'b0, e, "exec_i");
    e = '0;
    e.write_reg = 1'b1;
    e.w_r_s = 2'b01;
    e.instr_done = 1'b1;
    cyc(idle_rdy, 1'b0, e, "wb_i");
  endtask

  task automatic branch(input logic [5:0] op, input logic z, input logic take);
    cw_t e = '0;
    set_ir(op, 6'b000000);
    fetch(0);
    decode_go();
    e.alu_op = 3'b101;
    e.pc_s = 2'b10;
    e.pc_we = take;
    e.instr_done = 1'b1;
    cyc(idle_rdy, z, e, "exec_br");
  endtask

  task automatic memop(input logic is_sw, input int fw, input int mw);
    cw_t e = '0;
    set_ir(is_sw ? 6'b101011 : 6'b100011, 6'b000000);
    fetch(fw);
    decode_go();
    e.alu_op = 3'b100;
    e.imm_s = 1'b1;
    e.rt_imm_s = 1'b1;
    cyc(idle_rdy, 1'b0, e, "exec_mem");
    e.mem_req = 1'b1;
    e.mem_write = is_sw;
    repeat (mw) cyc(1'b0, 1'b0, e, "mem_wait");
    if (is_sw) e.instr_done = 1'b1;
    cyc(1'b1, 1'b0, e, "mem");
    if (!is_sw) begin
      e = '0;
      e.write_reg = 1'b1;
      e.w_r_s = 2'b01;
      e.w_r_data_s = 2'b01;
      e.instr_done = 1'b1;
      cyc(idle_rdy, 1'b0, e, "wb_lw");
    end
  endtask

  task automatic jump(input logic link);
    cw_t e = '0;
    set_ir(link ? 6'b000011 : 6'b000010, 6'b000000);
    fetch(0);
    e.pc_we = 1'b1;
    e.pc_s = 2'b11;
    e.instr_done = 1'b1;
    if (link) begin
      e.write_reg = 1'b1;
      e.w_r_s = 2'b10;
      e.w_r_data_s = 2'b10;
    end
    cyc(idle_rdy, 1'b0, e, "decode_j");
  endtask

  task automatic illegal_instr(input logic [5:0] op, input logic [5:0] fn);
    cw_t e = '0;
    set_ir(op, fn);
    fetch(0);
    e.illegal = 1'b1;
    e.instr_done = 1'b1;
    cyc(idle_rdy, 1'b0, e, "decode_ill");
  endtask

  initial begin
    cw_t e, e2;
    @(posedge clk);
    #1;
    // reset: state is FETCH but everything, mem_req included, must be held low
    cyc(1'b1, 1'b0, '0, "reset");
    cyc(1'b1, 1'b0, '0, "reset");
    rst = 1'b0;

    // jal: linked jump on the JAL_EN=1 core, illegal on the JAL_EN=0 core
    chk2 = 1'b1;
    set_ir(6'b000011, 6'b000000);
    fetch(0);
    chk2 = 1'b0;
    e = '0;
    e.pc_we = 1'b1;
    e.pc_s = 2'b11;
    e.write_reg = 1'b1;
    e.w_r_s = 2'b10;
    e.w_r_data_s = 2'b10;
    e.instr_done = 1'b1;
    e2 = '0;
    e2.illegal = 1'b1;
    e2.instr_done = 1'b1;
    cycd(e, e2, "decode_jal");

    jump(1'b0);

    // R-type with mem_ready held high outside memory phases
    idle_rdy = 1'b1;
    r_alu(6'b100000, 3'b100);   // add
    r_alu(6'b100010, 3'b101);   // sub
    r_alu(6'b100100, 3'b000);   // and
    r_alu(6'b100111, 3'b011);   // nor
    r_alu(6'b101011, 3'b110);   // sltu
    r_alu(6'b000100, 3'b111);   // sllv
    idle_rdy = 1'b0;

    // jr
    set_ir(6'b000000, 6'b001000);
    fetch(0);
    decode_go();
    e = '0;
    e.pc_we = 1'b1;
    e.pc_s = 2'b01;
    e.instr_done = 1'b1;
    cyc(1'b0, 1'b0, e, "exec_jr");

    i_alu(6'b001000, 3'b100, 1'b1);  // addi
    i_alu(6'b001100, 3'b000, 1'b0);  // andi
    i_alu(6'b001101, 3'b001, 1'b0);  // ori
    i_alu(6'b001110, 3'b010, 1'b0);  // xori
    i_alu(6'b001011, 3'b110, 1'b1);  // sltiu

    branch(6'b000100, 1'b1, 1'b1);   // beq taken
    branch(6'b000101, 1'b1, 1'b0);   // bne not taken
    branch(6'b000100, 1'b0, 1'b0);   // beq not taken
    branch(6'b000101, 1'b0, 1'b1);   // bne taken

    memop(1'b0, 2, 3);               // lw, 10 cycles
    memop(1'b1, 0, 0);               // sw, 4 cycles
    memop(1'b1, 1, 2);               // sw with waits

    illegal_instr(6'b111111, 6'b000000);
    illegal_instr(6'b000000, 6'b000001);
    illegal_instr(6'b001001, 6'b000000);

    // reset in the middle of an sw data access
    set_ir(6'b101011, 6'b000000);
    fetch(0);
    decode_go();
    e = '0;
    e.alu_op = 3'b100;
    e.imm_s = 1'b1;
    e.rt_imm_s = 1'b1;
    cyc(1'b0, 1'b0, e, "exec_mem");
    e.mem_req = 1'b1;
    e.mem_write = 1'b1;
    cyc(1'b0, 1'b0, e, "mem_wait");
    rst = 1'b1;
    #1;
    chk("rst_async_drop", ob1, '0);
    cyc(1'b1, 1'b0, '0, "in_reset");
    rst = 1'b0;
    r_alu(6'b100000, 3'b100);

    // memory timeout during sw: 4 wait cycles, then ERR for good
    set_ir(6'b101011, 6'b000000);
    fetch(0);
    decode_go();
    e = '0;
    e.alu_op = 3'b100;
    e.imm_s = 1'b1;
    e.rt_imm_s = 1'b1;
    cyc(1'b0, 1'b0, e, "exec_mem");
    e.mem_req = 1'b1;
    e.mem_write = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, e, "mem_timeout_wait");
    e = '0;
    e.mem_err = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, e, "err");

    repeat (2) @(posedge clk);
    if (q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0", q1.size(), q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
